// File: rtl/inst_mem_responder_pkg.sv
// Shared constants for the instruction-memory responder: data/address widths
// and the filler word returned for bad fetches.
package inst_mem_responder_pkg;
   localparam int unsigned INST_W = 32;
   localparam int unsigned ADDR_W = 64;
   localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
endpackage

// File: rtl/inst_mem_lat_pipe.sv
// Fixed-depth valid/data/error shift pipeline; flush kills every stage holding an
// older entry while the entry loaded at the same edge survives.
module inst_mem_lat_pipe
   import inst_mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = INST_W
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_flush,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_err,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic             o_err
);

   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] err_q;
   logic [WIDTH-1:0] data_q [DEPTH];

   // Data only advances with a valid entry, so the last stage holds the last response.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q <= '0;
         err_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         valid_q[0] <= i_valid;
         err_q[0]   <= i_valid & i_err;
         if (i_valid) begin
            data_q[0] <= i_data;
         end
         for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1] & ~i_flush;
            err_q[i]   <= err_q[i-1] & ~i_flush;
            if (valid_q[i-1] && !i_flush) begin
               data_q[i] <= data_q[i-1];
            end
         end
      end
   end

   assign o_valid = valid_q[DEPTH-1];
   assign o_data  = data_q[DEPTH-1];
   assign o_err   = err_q[DEPTH-1];

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-memory responder: fixed-latency in-order fetch responses, preload
// write port, redirect flush and address-error reporting.
module inst_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2,
   parameter logic [inst_mem_responder_pkg::INST_W-1:0] NOP_INST =
      inst_mem_responder_pkg::NOP_INST
) (
   input  logic                                        i_clk,
   input  logic                                        i_rst_n,
   input  logic                                        i_valid_addr,
   input  logic [inst_mem_responder_pkg::ADDR_W-1:0]   i_addr,
   input  logic                                        i_flush,
   input  logic                                        i_ld_valid,
   input  logic [$clog2(DEPTH_WORDS)-1:0]              i_ld_addr,
   input  logic [inst_mem_responder_pkg::INST_W-1:0]   i_ld_data,
   output logic                                        o_valid_inst,
   output logic [inst_mem_responder_pkg::INST_W-1:0]   o_inst,
   output logic                                        o_addr_err,
   output logic [3:0]                                  o_inflight
);
   import inst_mem_responder_pkg::*;

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   logic [INST_W-1:0] mem [DEPTH_WORDS];
   logic [AW-1:0]     rd_idx;
   logic              addr_err;
   logic [INST_W-1:0] rd_data;
   logic [3:0]        inflight_q;
   logic [3:0]        inflight_d;

   always_comb begin
      rd_idx   = i_addr[AW+1:2];
      addr_err = (i_addr[1:0] != 2'b00) || (i_addr[ADDR_W-1:AW+2] != '0);
      rd_data  = addr_err ? NOP_INST : mem[rd_idx];
   end

   // Storage is deliberately not reset; the pipeline samples rd_data at the same
   // edge as a preload write, which gives read-before-write on a collision.
   always_ff @(posedge i_clk) begin
      if (i_ld_valid) begin
         mem[i_ld_addr] <= i_ld_data;
      end
   end

   inst_mem_lat_pipe #(
      .DEPTH (LATENCY),
      .WIDTH (INST_W)
   ) u_pipe (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_flush (i_flush),
      .i_valid (i_valid_addr),
      .i_data  (rd_data),
      .i_err   (addr_err),
      .o_valid (o_valid_inst),
      .o_data  (o_inst),
      .o_err   (o_addr_err)
   );

   always_comb begin
      inflight_d = inflight_q;
      if (i_flush) begin
         inflight_d = {3'b000, i_valid_addr};
      end else begin
         inflight_d = inflight_q + 4'(i_valid_addr) - 4'(o_valid_inst);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         inflight_q <= '0;
      end else begin
         inflight_q <= inflight_d;
      end
   end

   assign o_inflight = inflight_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench for inst_mem_responder: two instances (latency 2 and 3) share stimulus and
// are checked against a request-log model of the fetch/flush/reset rules.
module tb_inst_mem_responder;

   localparam int MAXE = 4096;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        valid_addr;
   logic [63:0] addr;
   logic        flush;
   logic        ld_valid;
   logic [9:0]  ld_addr;
   logic [31:0] ld_data;

   logic        obs_v    [2];
   logic [31:0] obs_inst [2];
   logic        obs_err  [2];
   logic [3:0]  obs_infl [2];

   inst_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .NOP_INST(NOP)) u_dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid_addr(valid_addr), .i_addr(addr),
      .i_flush(flush), .i_ld_valid(ld_valid), .i_ld_addr(ld_addr), .i_ld_data(ld_data),
      .o_valid_inst(obs_v[0]), .o_inst(obs_inst[0]), .o_addr_err(obs_err[0]),
      .o_inflight(obs_infl[0])
   );

   inst_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(3), .NOP_INST(NOP)) u_dut3 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid_addr(valid_addr), .i_addr(addr),
      .i_flush(flush), .i_ld_valid(ld_valid), .i_ld_addr(ld_addr), .i_ld_data(ld_data),
      .o_valid_inst(obs_v[1]), .o_inst(obs_inst[1]), .o_addr_err(obs_err[1]),
      .o_inflight(obs_infl[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: a log of what was accepted at each edge, plus per-latency kill marks.
   logic [31:0] mem_m  [1024];
   bit          rec_v  [MAXE];
   logic [31:0] rec_d  [MAXE];
   bit          rec_e  [MAXE];
   bit          killed [2][MAXE];
   int          edge_n;
   bit          exp_v    [2];
   logic [31:0] exp_inst [2];
   bit          exp_err  [2];
   int          exp_infl [2];
   int          checks;
   int          errors;
   logic [31:0] wa, wb, wc;

   function automatic int lat(int k);
      return (k == 0) ? 2 : 3;
   endfunction

   // Advance one clock edge using the inputs currently driven, updating the model.
   task automatic tick();
      int e = edge_n;
      if (rst_n) begin
         if (flush) begin
            for (int k = 0; k < 2; k++) begin
               for (int j = e - lat(k) + 1; j < e; j++) begin
                  if (j >= 0) killed[k][j] = 1'b1;
               end
            end
         end
         rec_v[e] = valid_addr;
         rec_e[e] = (addr % 4 != 0) || (addr >= 64'd4096);
         rec_d[e] = rec_e[e] ? NOP : mem_m[addr[11:2]];
      end else begin
         rec_v[e] = 1'b0;
      end
      if (ld_valid) mem_m[ld_addr] = ld_data;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         int a = e - lat(k) + 1;
         exp_v[k] = (a >= 0) && rec_v[a] && !killed[k][a];
         exp_err[k] = exp_v[k] && rec_e[a];
         if (exp_v[k]) exp_inst[k] = rec_d[a];
         exp_infl[k] = 0;
         for (int j = (a < 0 ? 0 : a); j <= e; j++) begin
            if (rec_v[j] && !killed[k][j]) exp_infl[k]++;
         end
      end
      edge_n++;
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      valid_addr = 1'b0;
      addr       = '0;
      flush      = 1'b0;
      ld_valid   = 1'b0;
      ld_addr    = '0;
      ld_data    = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      tick();
      tick();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (obs_v[k] !== 1'b0) begin
            errors++; $display("FAIL reset_valid[%0d] got %0b want 0", k, obs_v[k]);
         end
         checks++;
         if (obs_inst[k] !== 32'h0) begin
            errors++; $display("FAIL reset_inst[%0d] got %h want 0", k, obs_inst[k]);
         end
         checks++;
         if (obs_err[k] !== 1'b0) begin
            errors++; $display("FAIL reset_err[%0d] got %0b want 0", k, obs_err[k]);
         end
         checks++;
         if (obs_infl[k] !== 4'd0) begin
            errors++; $display("FAIL reset_infl[%0d] got %0d want 0", k, obs_infl[k]);
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic preload_all();
      for (int i = 0; i < 1024; i++) begin
         ld_valid = 1'b1;
         ld_addr  = 10'(i);
         ld_data  = (i == 0) ? 32'h0050_0093 : $urandom;
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_basic();
      bit v2_tab [3] = '{1'b0, 1'b1, 1'b0};
      bit v3_tab [3] = '{1'b0, 1'b0, 1'b1};
      for (int c = 0; c < 3; c++) begin
         valid_addr = (c == 0);
         addr       = 64'h0;
         tick();
         checks++;
         if (obs_v[0] !== v2_tab[c] || obs_v[1] !== v3_tab[c]) begin
            errors++;
            $display("FAIL basic_valid c=%0d got %0b/%0b want %0b/%0b", c, obs_v[0], obs_v[1],
                     v2_tab[c], v3_tab[c]);
         end
         if (c == 1) begin
            checks++;
            if (obs_inst[0] !== 32'h0050_0093 || obs_err[0] !== 1'b0) begin
               errors++;
               $display("FAIL basic_inst2 got %h err %0b want 00500093 err 0", obs_inst[0],
                        obs_err[0]);
            end
         end
         if (c == 2) begin
            checks++;
            if (obs_inst[1] !== 32'h0050_0093) begin
               errors++; $display("FAIL basic_inst3 got %h want 00500093", obs_inst[1]);
            end
         end
      end
      idle_inputs();
   endtask

   task automatic test_streaming();
      logic [31:0] words [3];
      int peak [2] = '{0, 0};
      wa = $urandom; wb = $urandom; wc = $urandom;
      words = '{wa, wb, wc};
      for (int i = 0; i < 3; i++) begin
         ld_valid = 1'b1; ld_addr = 10'(i); ld_data = words[i];
         tick();
      end
      idle_inputs();
      for (int c = 0; c < 6; c++) begin
         valid_addr = (c < 3);
         addr       = 64'(c * 4);
         tick();
         for (int k = 0; k < 2; k++) begin
            int slot = c - lat(k) + 1;
            bit want_v = (slot >= 0) && (slot < 3);
            if (int'(obs_infl[k]) > peak[k]) peak[k] = int'(obs_infl[k]);
            checks++;
            if (obs_v[k] !== want_v || (want_v && obs_inst[k] !== words[slot])) begin
               errors++;
               $display("FAIL stream[%0d] c=%0d got v=%0b %h want v=%0b %h", k, c, obs_v[k],
                        obs_inst[k], want_v, want_v ? words[slot] : obs_inst[k]);
            end
         end
      end
      checks++;
      if (peak[0] != 2 || peak[1] != 3) begin
         errors++; $display("FAIL stream_peak got %0d/%0d want 2/3", peak[0], peak[1]);
      end
      idle_inputs();
   endtask

   task automatic test_errors();
      logic [63:0] bad [2] = '{64'h2, 64'h1000};
      for (int c = 0; c < 4; c++) begin
         valid_addr = (c < 2);
         addr       = (c < 2) ? bad[c] : 64'h0;
         tick();
         if (c == 1 || c == 2) begin
            checks++;
            if (obs_v[0] !== 1'b1 || obs_inst[0] !== 32'h13 || obs_err[0] !== 1'b1) begin
               errors++;
               $display("FAIL err_resp c=%0d got v=%0b %h err=%0b want 1 00000013 1", c,
                        obs_v[0], obs_inst[0], obs_err[0]);
            end
         end
         if (c == 3) begin
            checks++;
            if (obs_v[1] !== 1'b1 || obs_inst[1] !== 32'h13 || obs_err[1] !== 1'b1) begin
               errors++;
               $display("FAIL err_resp3 got v=%0b %h err=%0b want 1 00000013 1", obs_v[1],
                        obs_inst[1], obs_err[1]);
            end
            checks++;
            if (obs_err[0] !== 1'b0) begin
               errors++; $display("FAIL err_idle got %0b want 0", obs_err[0]);
            end
         end
      end
      idle_inputs();
   endtask

   task automatic test_flush();
      bit v2_tab [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      bit v3_tab [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int c = 0; c < 6; c++) begin
         valid_addr = (c < 3);
         addr       = 64'(c * 4);
         flush      = (c == 2);
         tick();
         checks++;
         if (obs_v[0] !== v2_tab[c] || obs_v[1] !== v3_tab[c]) begin
            errors++;
            $display("FAIL flush_valid c=%0d got %0b/%0b want %0b/%0b", c, obs_v[0], obs_v[1],
                     v2_tab[c], v3_tab[c]);
         end
         if (c == 2) begin
            checks++;
            if (obs_infl[0] !== 4'd1 || obs_infl[1] !== 4'd1) begin
               errors++;
               $display("FAIL flush_infl got %0d/%0d want 1/1", obs_infl[0], obs_infl[1]);
            end
         end
         if (c == 1 || c == 3) begin
            checks++;
            if (obs_inst[0] !== ((c == 1) ? wa : wc)) begin
               errors++; $display("FAIL flush_inst2 c=%0d got %h", c, obs_inst[0]);
            end
         end
         if (c == 4 || c == 5) begin
            checks++;
            if (obs_inst[1] !== wc || obs_err[1] !== 1'b0) begin
               errors++;
               $display("FAIL flush_inst3 c=%0d got %h err %0b want %h err 0", c, obs_inst[1],
                        obs_err[1], wc);
            end
         end
      end
      idle_inputs();
   endtask

   task automatic test_collision();
      logic [31:0] x = $urandom;
      logic [31:0] y = ~x;
      ld_valid = 1'b1; ld_addr = 10'd5; ld_data = x;
      tick();
      for (int c = 0; c < 4; c++) begin
         valid_addr = (c < 2);
         addr       = 64'd20;
         ld_valid   = (c == 0);
         ld_data    = y;
         tick();
         if (c == 1 || c == 2) begin
            checks++;
            if (obs_v[0] !== 1'b1 || obs_inst[0] !== ((c == 1) ? x : y)) begin
               errors++;
               $display("FAIL collision c=%0d got v=%0b %h want 1 %h", c, obs_v[0],
                        obs_inst[0], (c == 1) ? x : y);
            end
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset_midflight();
      valid_addr = 1'b1; addr = 64'h4;
      tick();
      idle_inputs();
      tick();
      rst_n = 1'b0;
      #1;
      for (int j = 0; j < MAXE; j++) rec_v[j] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         exp_v[k] = 1'b0; exp_inst[k] = '0; exp_err[k] = 1'b0; exp_infl[k] = 0;
         checks++;
         if (obs_v[k] !== 1'b0 || obs_inst[k] !== 32'h0 || obs_err[k] !== 1'b0 ||
             obs_infl[k] !== 4'd0) begin
            errors++;
            $display("FAIL midrst_out[%0d] got v=%0b %h err=%0b infl=%0d want all 0", k,
                     obs_v[k], obs_inst[k], obs_err[k], obs_infl[k]);
         end
      end
      @(negedge clk);
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if (obs_v[0] !== 1'b0 || obs_v[1] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ghost c=%0d got %0b/%0b want 0/0", c, obs_v[0], obs_v[1]);
         end
      end
      valid_addr = 1'b1; addr = 64'h4;
      tick();
      idle_inputs();
      tick();
      checks++;
      if (obs_v[0] !== 1'b1 || obs_inst[0] !== wb) begin
         errors++;
         $display("FAIL midrst_mem got v=%0b %h want 1 %h", obs_v[0], obs_inst[0], wb);
      end
      tick();
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         int sel = $urandom_range(0, 9);
         valid_addr = ($urandom_range(0, 9) < 7);
         if (sel < 8) addr = 64'($urandom_range(0, 1023)) * 4;
         else if (sel == 8) addr = 64'($urandom_range(0, 4095)) | 64'h1;
         else addr = {32'($urandom), 32'($urandom)} | 64'h1000;
         flush    = ($urandom_range(0, 11) == 0);
         ld_valid = ($urandom_range(0, 2) == 0);
         ld_addr  = ($urandom_range(0, 3) == 0) ? addr[11:2] : 10'($urandom);
         ld_data  = $urandom;
         tick();
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_v[k] !== exp_v[k]) begin
               errors++;
               $display("FAIL rand_valid[%0d] c=%0d got %0b want %0b", k, c, obs_v[k],
                        exp_v[k]);
            end
            checks++;
            if (obs_inst[k] !== exp_inst[k]) begin
               errors++;
               $display("FAIL rand_inst[%0d] c=%0d got %h want %h", k, c, obs_inst[k],
                        exp_inst[k]);
            end
            checks++;
            if (obs_err[k] !== exp_err[k]) begin
               errors++;
               $display("FAIL rand_err[%0d] c=%0d got %0b want %0b", k, c, obs_err[k],
                        exp_err[k]);
            end
            checks++;
            if (obs_infl[k] !== 4'(exp_infl[k])) begin
               errors++;
               $display("FAIL rand_infl[%0d] c=%0d got %0d want %0d", k, c, obs_infl[k],
                        exp_infl[k]);
            end
         end
      end
      idle_inputs();
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      edge_n   = 0;
      exp_inst = '{32'h0, 32'h0};
      @(negedge clk);
      test_reset();
      preload_all();
      test_basic();
      test_streaming();
      test_errors();
      test_flush();
      test_collision();
      test_reset_midflight();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
- Instruction-memory responder: the memory side of the fetch address/instruction handshake.
- Accepts one fetch address per cycle (valid/address) and returns the 32-bit instruction word a fixed LATENCY cycles later (valid/instruction), in request order.
- Includes a word-write load port for program preload, a flush input that kills in-flight responses on redirect, and an address-error flag.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words stored; power of two.
- LATENCY, 2: cycles from request acceptance to response; legal range 1..8.
- NOP_INST, 32'h00000013: word returned on an erroneous fetch.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid_addr  in  1  fetch request valid.
- i_addr  in  64  fetch byte address.
- i_flush  in  1  drop all in-flight responses.
- i_ld_valid  in  1  preload write strobe.
- i_ld_addr  in  log2(DEPTH_WORDS)  preload word index.
- i_ld_data  in  32  preload data.
- o_valid_inst  out  1  response valid, one-cycle pulse per request.
- o_inst  out  32  instruction word.
- o_addr_err  out  1  response is for a misaligned or out-of-range address.
- o_inflight  out  4  number of requests accepted but not yet responded.

Behaviour:
- Reset (asynchronous):
  - o_valid_inst, o_inst, o_addr_err and o_inflight go to 0.
  - All pipeline valid bits are cleared, so in-flight requests are dropped.
  - Memory contents are not reset.
- Acceptance: every cycle with i_valid_addr=1 accepts a request. There is no backpressure.
- Word index = i_addr[2+AW-1:2], where AW = log2(DEPTH_WORDS).
- Error condition: i_addr[1:0] != 0, or i_addr >= DEPTH_WORDS*4 (any upper bit set).
- Read timing: memory is read at the acceptance edge. Data, error bit and valid then travel through a LATENCY-stage pipeline.
- Response timing: request accepted at edge N gives o_valid_inst=1 during the cycle after edge N+LATENCY-1. For example, with LATENCY=1 the response is registered at the same edge that accepts the request.
- All outputs are registered.
- Normal response: o_inst = mem[index], o_addr_err=0.
- Error response: o_inst = NOP_INST, o_addr_err=1, same latency.
- When o_valid_inst=0: o_inst holds its last value and o_addr_err=0.
- Ordering: responses are strictly in request order. Back-to-back requests give back-to-back responses.
- Preload:
  - With i_ld_valid=1, mem[i_ld_addr] is written at the edge.
  - Preload and fetch may happen in the same cycle.
  - Same word, same edge: the fetch returns the OLD data (read-before-write).
- Flush:
  - i_flush=1 at an edge clears every pipeline stage holding an older request.
  - A request accepted at that same edge survives and responds normally.
  - A response already present on the outputs in that cycle is not retracted.
  - After a flush edge, o_valid_inst=0 until the surviving request, if any, arrives.
- o_inflight: +1 per accepted request, -1 per response leaving the last stage, set to 0 on reset. On flush it becomes 1 if a request is accepted at the flush edge, else 0. Never exceeds LATENCY.
- Reset mid-operation: no response ever appears for any request accepted before reset.

Decomposition:
- Shared package holds NOP_INST, the instruction width (32) and the address width (64).
- One sub-module, inst_mem_lat_pipe: a parameterised valid/data/error shift pipeline of depth LATENCY with a flush input.
- The storage array and address decode stay in inst_mem_responder.

Test Plan:
- Basic read: LATENCY=2; preload mem[0]=32'h00500093; request addr 0 at edge N -> o_valid_inst=1, o_inst=32'h00500093 after edge N+1, o_addr_err=0, single pulse.
- Streaming: preload words 0..2 = A,B,C; requests to 0x0, 0x4, 0x8 on consecutive edges -> A, B, C on three consecutive cycles; o_inflight peaks at 2.
- Errors: request 0x2 -> o_inst=32'h00000013, o_addr_err=1; request 0x1000 with DEPTH_WORDS=1024 -> same; both at normal latency.
- Flush: LATENCY=3; requests 0x0 at edge N and 0x4 at edge N+1, then i_flush=1 with a request to 0x8 at edge N+2 -> only the 0x8 response appears, after edge N+4; o_inflight=1 after the flush edge.
- Collision: preload and fetch of word 5 at the same edge (old X, new Y) -> response X; the next fetch of word 5 -> Y.
- Reset mid-flight: LATENCY=3; assert i_rst_n=0 one cycle after a request -> no response ever; outputs 0; memory contents intact after release.
